// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception/interrupt controller: register numbers,
// field positions, exception codes and the SR write mask.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_SR       = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IE_BIT     = 0;
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // Only IM, EXL and IE are software-writable in SR.
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage control/data bundle between the pipeline core (master) and CP0 (slave).
interface cp0_unit_if;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [31:0] bad_vaddr_m;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret_m;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        req;
  logic [31:0] handler_pc;

  // req is a single-cycle combinational strobe with no ready: the core must flush
  // and redirect to handler_pc in the same cycle it sees req high.
  modport master (
    output pc_m, bd_m, exc_code_m, bad_vaddr_m, hw_int,
    output cp0_we, cp0_addr, cp0_wdata, eret_m,
    input  cp0_rdata, epc_out, req, handler_pc
  );

  modport slave (
    input  pc_m, bd_m, exc_code_m, bad_vaddr_m, hw_int,
    input  cp0_we, cp0_addr, cp0_wdata, eret_m,
    output cp0_rdata, epc_out, req, handler_pc
  );
endinterface

// File: rtl/cp0_req_gen.sv
// Combinational interrupt/exception request logic; interrupts take priority and
// select ExcCode 0, everything is masked while EXL is set.
module cp0_req_gen
  import cp0_pkg::*;
(
  input  logic [5:0] sr_im,
  input  logic       sr_exl,
  input  logic       sr_ie,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code_m,
  output logic       int_req,
  output logic       exc_req,
  output logic       req,
  output logic [4:0] sel_exc_code
);

  // Live interrupt lines are used, not the IP bits latched last cycle.
  assign int_req      = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req      = (exc_code_m != EXC_INT) & ~sr_exl;
  assign req          = int_req | exc_req;
  assign sel_exc_code = int_req ? EXC_INT : exc_code_m;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR, Cause, EPC (and BadVAddr when CP0_BADVADDR_EN is defined),
// exception/interrupt request generation, mtc0/mfc0/eret servicing.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          NUM_HWINT  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  cp0_unit_if.slave   bus
);

  logic [5:0]           sr_im;
  logic                 sr_exl;
  logic                 sr_ie;
  logic                 cause_bd;
  logic [NUM_HWINT-1:0] cause_ip;
  logic [4:0]           cause_exc;
  logic [31:0]          epc;

  logic        int_req;
  logic        exc_req;
  logic        req_raw;
  logic [4:0]  sel_exc_code;
  logic [31:0] epc_next;
  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  cp0_req_gen u_req_gen (
    .sr_im        (sr_im),
    .sr_exl       (sr_exl),
    .sr_ie        (sr_ie),
    .hw_int       (bus.hw_int),
    .exc_code_m   (bus.exc_code_m),
    .int_req      (int_req),
    .exc_req      (exc_req),
    .req          (req_raw),
    .sel_exc_code (sel_exc_code)
  );

  // A delay-slot fault restarts at the branch so the branch re-executes.
  assign epc_next = (bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m) & ~32'h3;
  assign sr_wr    = bus.cp0_we & ~req_raw & (bus.cp0_addr == CP0_REG_SR);
  assign epc_wr   = bus.cp0_we & ~req_raw & (bus.cp0_addr == CP0_REG_EPC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= bus.hw_int;
      if (req_raw) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.bd_m;
        cause_exc <= sel_exc_code;
        epc       <= epc_next;
      end else begin
        if (sr_wr) begin
          sr_im  <= bus.cp0_wdata[SR_IM_LSB +: 6];
          sr_exl <= bus.cp0_wdata[SR_EXL_BIT];
          sr_ie  <= bus.cp0_wdata[SR_IE_BIT];
        end
        if (epc_wr) epc <= bus.cp0_wdata & ~32'h3;
        // Placed after the SR write so eret overrides the written EXL bit.
        if (bus.eret_m) sr_exl <= 1'b0;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_vaddr <= '0;
    end else if (exc_req && is_addr_exc(bus.exc_code_m)) begin
      bad_vaddr <= bus.bad_vaddr_m;
    end
  end
`else
  logic unused_bad_vaddr;
  assign unused_bad_vaddr = ^bus.bad_vaddr_m;
`endif

  always_comb begin
    sr_word                           = '0;
    sr_word[SR_IM_LSB +: 6]           = sr_im;
    sr_word[SR_EXL_BIT]               = sr_exl;
    sr_word[SR_IE_BIT]                = sr_ie;
    cause_word                        = '0;
    cause_word[CAUSE_BD_BIT]          = cause_bd;
    cause_word[CAUSE_IP_LSB +: 6]     = cause_ip;
    cause_word[CAUSE_EXC_LSB +: 5]    = cause_exc;
  end

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      CP0_REG_SR:       bus.cp0_rdata = sr_word;
      CP0_REG_CAUSE:    bus.cp0_rdata = cause_word;
      CP0_REG_EPC:      bus.cp0_rdata = epc;
`ifdef CP0_BADVADDR_EN
      CP0_REG_BADVADDR: bus.cp0_rdata = bad_vaddr;
`endif
      default:          bus.cp0_rdata = '0;
    endcase
  end

  // Gated so a pending decoder exception cannot raise req while held in reset.
  assign bus.req        = req_raw & rst_n;
  assign bus.epc_out    = epc;
  assign bus.handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed vector table, async reset sequence, then random
// stimulus checked against a register-level reference model.
module tb_cp0_unit;

  logic clk;
  logic rst_n;
  cp0_unit_if bus();

  cp0_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_total++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_sr, m_cause, m_epc, m_bva;

  task automatic model_reset();
    m_sr = 0; m_cause = 0; m_epc = 0; m_bva = 0;
  endtask

  function automatic bit model_int(input logic [5:0] hw);
    return ((hw & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit model_req(input logic [5:0] hw, input logic [4:0] code);
    return model_int(hw) || (code != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
`ifdef CP0_BADVADDR_EN
      5'd8:  return m_bva;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    bit ir, er;
    ir = model_int(bus.hw_int);
    er = (bus.exc_code_m != 0) && !m_sr[1];
    if (ir || er) begin
      m_sr[1]      = 1'b1;
      m_cause[31]  = bus.bd_m;
      m_cause[6:2] = ir ? 5'd0 : bus.exc_code_m;
      m_epc        = (bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m) & ~32'h3;
      if (er && (bus.exc_code_m == 5'd4 || bus.exc_code_m == 5'd5)) m_bva = bus.bad_vaddr_m;
    end else begin
      if (bus.cp0_we && bus.cp0_addr == 5'd12) m_sr = bus.cp0_wdata & 32'h0000_FC03;
      if (bus.cp0_we && bus.cp0_addr == 5'd14) m_epc = bus.cp0_wdata & ~32'h3;
      if (bus.eret_m) m_sr[1] = 1'b0;
    end
    m_cause[15:10] = bus.hw_int;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] hw, input logic [4:0] code, input logic bd,
                       input logic [31:0] pc, input logic [31:0] bad, input logic we,
                       input logic [4:0] addr, input logic [31:0] wdata, input logic eret);
    bus.hw_int      = hw;
    bus.exc_code_m  = code;
    bus.bd_m        = bd;
    bus.pc_m        = pc;
    bus.bad_vaddr_m = bad;
    bus.cp0_we      = we;
    bus.cp0_addr    = addr;
    bus.cp0_wdata   = wdata;
    bus.eret_m      = eret;
  endtask

  task automatic idle();
    drive(6'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  // Advance one clock edge, keeping the model in step, and return at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  hw;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] bad;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic        exp_req;
    logic [31:0] exp_rdata;
  } vec_t;

`ifdef CP0_BADVADDR_EN
  localparam logic [31:0] BVA_EXP = 32'h0000_0003;
`else
  localparam logic [31:0] BVA_EXP = 32'h0000_0000;
`endif

  vec_t vec[20];
  int   codes_tbl[9] = '{0, 0, 0, 0, 4, 5, 8, 10, 12};
  int   addrs_tbl[6] = '{8, 12, 13, 14, 0, 20};

  initial begin
    //            hw     code   bd  pc            bad           we  addr   wdata          eret req rdata
    vec[0]  = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        0, 5'd12, 32'h0,         0,   0, 32'h0};
    vec[1]  = '{6'd0, 5'd12, 1, 32'h3008,    32'h0,        0, 5'd13, 32'h0,         0,   1, 32'h0};
    vec[2]  = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        0, 5'd13, 32'h0,         0,   0, 32'h8000_0030};
    vec[3]  = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        0, 5'd14, 32'h0,         0,   0, 32'h3004};
    vec[4]  = '{6'd0, 5'd8,  0, 32'h0,       32'h0,        0, 5'd12, 32'h0,         0,   0, 32'h2};
    vec[5]  = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        0, 5'd12, 32'h0,         1,   0, 32'h2};
    vec[6]  = '{6'd4, 5'd0,  0, 32'h0,       32'h0,        0, 5'd12, 32'h0,         0,   0, 32'h0};
    vec[7]  = '{6'd4, 5'd0,  0, 32'h0,       32'h0,        0, 5'd13, 32'h0,         0,   0, 32'h8000_1030};
    vec[8]  = '{6'd4, 5'd0,  0, 32'h0,       32'h0,        1, 5'd12, 32'h1001,      0,   0, 32'h0};
    vec[9]  = '{6'd4, 5'd10, 0, 32'h4000,    32'h0,        0, 5'd12, 32'h0,         0,   1, 32'h1001};
    vec[10] = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        0, 5'd13, 32'h0,         0,   0, 32'h1000};
    vec[11] = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        1, 5'd12, 32'hFFFF_FFFF, 1,   0, 32'h1003};
    vec[12] = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        1, 5'd14, 32'h3013,      0,   0, 32'h4000};
    vec[13] = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        1, 5'd13, 32'hFFFF_FFFF, 0,   0, 32'h0};
    vec[14] = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        0, 5'd14, 32'h0,         0,   0, 32'h3010};
    vec[15] = '{6'd0, 5'd4,  0, 32'h5000,    32'h3,        0, 5'd12, 32'h0,         0,   1, 32'hFC01};
    vec[16] = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        0, 5'd8,  32'h0,         0,   0, BVA_EXP};
    vec[17] = '{6'd0, 5'd0,  0, 32'h0,       32'h0,        0, 5'd13, 32'h0,         1,   0, 32'h10};
    vec[18] = '{6'd1, 5'd0,  0, 32'h6000,    32'h0,        0, 5'd12, 32'h0,         0,   1, 32'hFC01};
    vec[19] = '{6'd1, 5'd0,  0, 32'h0,       32'h0,        0, 5'd13, 32'h0,         0,   0, 32'h400};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    bus.cp0_addr = 5'd12; #1;
    exp_q.push_back(32'h0); check("reset_sr", bus.cp0_rdata);
    bus.cp0_addr = 5'd13; #1;
    exp_q.push_back(32'h0); check("reset_cause", bus.cp0_rdata);
    bus.cp0_addr = 5'd14; #1;
    exp_q.push_back(32'h0); check("reset_epc", bus.cp0_rdata);
    exp_q.push_back(32'h0); check("reset_req", {31'b0, bus.req});
    exp_q.push_back(32'h0000_4180); check("handler_pc", bus.handler_pc);
    rst_n = 1'b1;
    idle();
    step();

    // Directed vectors
    for (int i = 0; i < 20; i++) begin
      drive(vec[i].hw, vec[i].code, vec[i].bd, vec[i].pc, vec[i].bad,
            vec[i].we, vec[i].addr, vec[i].wdata, vec[i].eret);
      #1;
      exp_q.push_back({31'b0, vec[i].exp_req});
      check($sformatf("vec%0d_req", i), {31'b0, bus.req});
      exp_q.push_back(vec[i].exp_rdata);
      check($sformatf("vec%0d_rdata", i), bus.cp0_rdata);
      step();
    end

    // Leave EXL, take a fresh exception, then reset asynchronously mid-cycle
    // with a decoder exception still pending.
    drive(6'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    step();
    drive(6'd0, 5'd12, 1'b0, 32'h7000, 32'h0, 1'b0, 5'd12, 32'h0, 1'b0);
    step();
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(32'h0); check("midrst_req", {31'b0, bus.req});
    exp_q.push_back(32'h0); check("midrst_sr", bus.cp0_rdata);
    exp_q.push_back(32'h0); check("midrst_epc", bus.epc_out);
    bus.cp0_addr = 5'd13; #1;
    exp_q.push_back(32'h0); check("midrst_cause", bus.cp0_rdata);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    bus.cp0_addr = 5'd12; #1;
    exp_q.push_back(32'h0); check("post_rst_sr", bus.cp0_rdata);
    step();

    // Randomized phase against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] hw;
      hw = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      drive(hw,
            5'(codes_tbl[$urandom_range(0, 8)]),
            1'($urandom),
            $urandom,
            $urandom,
            ($urandom_range(0, 2) == 0),
            5'(addrs_tbl[$urandom_range(0, 5)]),
            $urandom,
            ($urandom_range(0, 3) == 0));
      #1;
      exp_q.push_back({31'b0, model_req(bus.hw_int, bus.exc_code_m)});
      check("rand_req", {31'b0, bus.req});
      exp_q.push_back(model_read(bus.cp0_addr));
      check("rand_rdata", bus.cp0_rdata);
      exp_q.push_back(m_epc);
      check("rand_epc_out", bus.epc_out);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
